// File: rtl/uart_pkg.sv
// Shared types and 8N1 framing constants for the flow-controlled UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_e;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with a registered head byte and occupancy count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req,
  input  logic [7:0]              wr_data,
  input  logic                    rd_ready,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    head_q, head_d;
  logic          pop, full, wr;

  always_comb begin
    pop    = (cnt_q != '0) && rd_ready;
    full   = (cnt_q == CW'(DEPTH));
    wr     = wr_req && (!full || pop);
    ovf    = wr_req && full && !pop;
    rd_nxt = rd_ptr_q + 1'b1;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    cnt_d    = cnt_q + CW'(wr) - CW'(pop);

    if (wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_nxt;

    // head register tracks what mem[rd_ptr] will hold next cycle
    if (cnt_q == '0) begin
      if (wr) head_d = wr_data;
    end else if (pop) begin
      if (cnt_q == CW'(1)) begin
        if (wr) head_d = wr_data;
      end else begin
        head_d = mem_q[rd_nxt];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  assign rd_data  = head_q;
  assign rd_valid = (cnt_q != '0);
  assign count    = cnt_q;

endmodule

// File: rtl/uart_rx_fc.sv
// 8N1 UART receiver with 16x oversampling, receive FIFO and RTS flow control.
module uart_rx_fc
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int RTS_THRESH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rts_b,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int CW = cnt_w(FIFO_DEPTH);

  rx_state_e     state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [9:0]    div_q, div_d;
  logic [3:0]    smp_q, smp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          rts_q, rts_d;
  logic          tick, mid, push, fe_set, ovf;
  logic [CW-1:0] count;

  always_comb begin
    tick    = (div_q == 10'(CLK_DIV - 1));
    mid     = tick && (smp_q == 4'(MID_SAMPLE));
    state_d = state_q;
    smp_d   = tick ? smp_q + 1'b1 : smp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    div_d   = (state_q == S_IDLE || tick) ? '0 : div_q + 1'b1;

    // smp wraps mod 16, so after START the mid count lands mid-bit
    unique case (state_q)
      S_IDLE: begin
        smp_d = '0;
        bit_d = '0;
        if (!sync2_q) state_d = S_START;
      end
      S_START: begin
        if (mid) state_d = sync2_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mid) begin
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          state_d = S_IDLE;
          push    = sync2_q;
          fe_set  = !sync2_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    frame_err_d = err_clr ? 1'b0 : (frame_err_q | fe_set);
    overrun_d   = err_clr ? 1'b0 : (overrun_q | ovf);
    rts_d       = (count >= CW'(RTS_THRESH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      div_q       <= '0;
      smp_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rts_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= rxd;
      sync2_q     <= sync1_q;
      div_q       <= div_d;
      smp_q       <= smp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rts_q       <= rts_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (push),
    .wr_data (shift_q),
    .rd_ready(rd_ready),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .count   (count),
    .ovf     (ovf)
  );

  assign rts_b     = rts_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
